// File: rtl/control_unit_pkg.sv
// Shared types and constants for the multi-cycle MIPS-subset control unit:
// FSM states, instruction classes, ALU codes, opcode/funct values,
// interrupt vectors, RAM size codes and flag bit positions.
package control_unit_pkg;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_CHK  = 4'd1,
    S_F0   = 4'd2,
    S_F1   = 4'd3,
    S_F2   = 4'd4,
    S_EX   = 4'd5,
    S_M0   = 4'd6,
    S_M1   = 4'd7,
    S_M2   = 4'd8,
    S_WB   = 4'd9,
    S_INT0 = 4'd10,
    S_INT1 = 4'd11,
    S_INT2 = 4'd12
  } state_t;

  typedef enum logic [3:0] {
    C_NOP   = 4'd0,
    C_ALU_R = 4'd1,
    C_ALU_I = 4'd2,
    C_LOAD  = 4'd3,
    C_STORE = 4'd4,
    C_BEQ   = 4'd5,
    C_BNE   = 4'd6,
    C_J     = 4'd7,
    C_JAL   = 4'd8,
    C_JR    = 4'd9,
    C_ERET  = 4'd10
  } iclass_t;

  // ALU operation codes
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1011;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_COP0  = 6'h10;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ERET  = 6'h18;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // Interrupt vector addresses in RAM
  localparam logic [8:0] VEC_HW   = 9'h1FC;
  localparam logic [8:0] VEC_MI   = 9'h1F8;

  // RAM transfer sizes
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // ALU-B operand sources
  localparam logic [1:0] MUXB_RT  = 2'b00;
  localparam logic [1:0] MUXB_IMM = 2'b01;
  localparam logic [1:0] MUXB_MDR = 2'b10;
  localparam logic [1:0] MUXB_PC  = 2'b11;

  // Special registers
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_EPC  = 5'd26;
  localparam logic [4:0] REG_RA   = 5'd31;

  // Flag bit positions in {V,C,N,Z}
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

  // Relative branch target: PC (already advanced) plus word offset, wrapping at 32 bits
  function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [15:0] imm);
    return pc + {{14{imm[15]}}, imm, 2'b00};
  endfunction

  // Absolute jump target inside the current 256 MB region
  function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [25:0] target);
    return {pc[31:28], target, 2'b00};
  endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational IR decode: instruction class, ALU op, immediate extension
// mode and RAM transfer size. Unknown encodings fall back to NOP.
module cu_decoder
  import control_unit_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic [3:0] aluop,
  output logic       sext,
  output logic [1:0] datasize
);

  // Map opcode/funct onto class and per-instruction attributes
  always_comb begin
    iclass   = C_NOP;
    aluop    = ALU_ADD;
    sext     = 1'b1;
    datasize = SIZE_WORD;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: begin iclass = C_ALU_R; aluop = ALU_ADD;  end
          FN_SUBU: begin iclass = C_ALU_R; aluop = ALU_SUB;  end
          FN_AND:  begin iclass = C_ALU_R; aluop = ALU_AND;  end
          FN_OR:   begin iclass = C_ALU_R; aluop = ALU_OR;   end
          FN_XOR:  begin iclass = C_ALU_R; aluop = ALU_XOR;  end
          FN_NOR:  begin iclass = C_ALU_R; aluop = ALU_NOR;  end
          FN_SLT:  begin iclass = C_ALU_R; aluop = ALU_SLT;  end
          FN_SLTU: begin iclass = C_ALU_R; aluop = ALU_SLTU; end
          FN_JR:   begin iclass = C_JR;                      end
          default: begin iclass = C_NOP;                     end
        endcase
      end
      OP_ADDIU: begin iclass = C_ALU_I; aluop = ALU_ADD;               end
      OP_SLTI:  begin iclass = C_ALU_I; aluop = ALU_SLT;               end
      OP_ANDI:  begin iclass = C_ALU_I; aluop = ALU_AND; sext = 1'b0;  end
      OP_ORI:   begin iclass = C_ALU_I; aluop = ALU_OR;  sext = 1'b0;  end
      OP_XORI:  begin iclass = C_ALU_I; aluop = ALU_XOR; sext = 1'b0;  end
      OP_LUI:   begin iclass = C_ALU_I; aluop = ALU_LUI;               end
      OP_LW:    begin iclass = C_LOAD;  datasize = SIZE_WORD;          end
      OP_LBU:   begin iclass = C_LOAD;  datasize = SIZE_BYTE;          end
      OP_SW:    begin iclass = C_STORE; datasize = SIZE_WORD;          end
      OP_SB:    begin iclass = C_STORE; datasize = SIZE_BYTE;          end
      OP_BEQ:   begin iclass = C_BEQ;   aluop = ALU_SUB;               end
      OP_BNE:   begin iclass = C_BNE;   aluop = ALU_SUB;               end
      OP_J:     begin iclass = C_J;                                    end
      OP_JAL:   begin iclass = C_JAL;                                  end
      OP_COP0: begin
        if (funct == FN_ERET) begin
          iclass = C_ERET;
        end else begin
          iclass = C_NOP;
        end
      end
      default:  begin iclass = C_NOP;                                  end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit for the 32-bit MIPS-subset datapath. A Moore FSM
// sequences fetch/decode/execute/memory/write-back and interrupt entry,
// driving every select, enable and RAM handshake line of the datapath.
module control_unit
  import control_unit_pkg::*;
(
  input  logic        Clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] currentPC,
  input  logic [3:0]  aluCarryFlags,
  input  logic        ramMFC,
  input  logic        hardwareInterrupt,
  input  logic        maskableInterrupt,
  output logic [31:0] nextPC,
  output logic        muxSignals5,
  output logic [3:0]  cmpsignal,
  output logic        trapMux,
  output logic        signExtend,
  output logic        clearPC,
  output logic        regFileRW,
  output logic [4:0]  regFileRD,
  output logic [4:0]  regFileRS,
  output logic [4:0]  regFileRT,
  output logic [1:0]  aluSign,
  output logic [3:0]  aluOperation,
  output logic [1:0]  ramDataSize,
  output logic        ramMFA,
  output logic        ramRW,
  output logic [8:0]  ramAddress,
  output logic        pcEnable,
  output logic        irEnable,
  output logic        marEnable,
  output logic        mdrEnable,
  output logic [1:0]  muxSignals,
  output logic        muxSignals2,
  output logic [1:0]  muxSignals3
);

  state_t      state_r, state_next_s;
  logic        ie_r, ie_next_s;
  logic [8:0]  vec_r, vec_next_s;

  iclass_t     iclass_s;
  logic [3:0]  aluop_s;
  logic        sext_s;
  logic [1:0]  size_s;

  logic [4:0]  rs_s, rt_s, rd_s;
  logic        zero_s;
  logic        taken_s;
  logic        unused_flags_s;

  assign rs_s   = instruction[25:21];
  assign rt_s   = instruction[20:16];
  assign rd_s   = instruction[15:11];
  assign zero_s = aluCarryFlags[FLAG_Z];
  // Only Z steers the sequencer; the remaining flags belong to the datapath
  assign unused_flags_s = ^aluCarryFlags[3:1];

  cu_decoder u_decoder (
    .opcode   (instruction[31:26]),
    .funct    (instruction[5:0]),
    .iclass   (iclass_s),
    .aluop    (aluop_s),
    .sext     (sext_s),
    .datasize (size_s)
  );

  // BEQ branches on Z=1, BNE on Z=0
  assign taken_s = (zero_s == (iclass_s == C_BEQ));

  // State, interrupt-enable and vector registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_r <= S_RST;
      ie_r    <= 1'b1;
      vec_r   <= 9'd0;
    end else begin
      state_r <= state_next_s;
      ie_r    <= ie_next_s;
      vec_r   <= vec_next_s;
    end
  end

  // Next-state and Moore output decode; every output idles at 0
  always_comb begin
    state_next_s = state_r;
    ie_next_s    = ie_r;
    vec_next_s   = vec_r;
    nextPC       = 32'd0;
    muxSignals5  = 1'b0;
    cmpsignal    = 4'b0000;
    trapMux      = 1'b0;
    signExtend   = 1'b0;
    clearPC      = 1'b0;
    regFileRW    = 1'b0;
    regFileRD    = REG_ZERO;
    regFileRS    = REG_ZERO;
    regFileRT    = REG_ZERO;
    aluSign      = 2'b00;
    aluOperation = 4'b0000;
    ramDataSize  = 2'b00;
    ramMFA       = 1'b0;
    ramRW        = 1'b0;
    ramAddress   = 9'd0;
    pcEnable     = 1'b0;
    irEnable     = 1'b0;
    marEnable    = 1'b0;
    mdrEnable    = 1'b0;
    muxSignals   = MUXB_RT;
    muxSignals2  = 1'b0;
    muxSignals3  = 2'b00;

    case (state_r)
      S_RST: begin
        clearPC      = 1'b1;
        state_next_s = S_CHK;
      end

      // Instruction boundary: the only place interrupts are accepted
      S_CHK: begin
        if (hardwareInterrupt) begin
          vec_next_s   = VEC_HW;
          ie_next_s    = 1'b0;
          state_next_s = S_INT0;
        end else if (maskableInterrupt && ie_r) begin
          vec_next_s   = VEC_MI;
          ie_next_s    = 1'b0;
          state_next_s = S_INT0;
        end else begin
          state_next_s = S_F0;
        end
      end

      S_F0: begin
        muxSignals   = MUXB_PC;
        aluOperation = ALU_ADD;
        marEnable    = 1'b1;
        state_next_s = S_F1;
      end

      S_F1: begin
        ramMFA      = 1'b1;
        ramRW       = 1'b1;
        ramDataSize = SIZE_WORD;
        if (ramMFC) begin
          irEnable     = 1'b1;
          state_next_s = S_F2;
        end else begin
          state_next_s = S_F1;
        end
      end

      S_F2: begin
        nextPC       = currentPC + 32'd4;
        muxSignals5  = 1'b1;
        pcEnable     = 1'b1;
        state_next_s = S_EX;
      end

      S_EX: begin
        state_next_s = S_CHK;
        if (iclass_s != C_NOP) begin
          signExtend = sext_s;
        end else begin
          signExtend = 1'b0;
        end
        case (iclass_s)
          C_ALU_R: begin
            regFileRS    = rs_s;
            regFileRT    = rt_s;
            muxSignals   = MUXB_RT;
            regFileRD    = rd_s;
            aluOperation = aluop_s;
            regFileRW    = 1'b1;
          end
          C_ALU_I: begin
            regFileRS    = rs_s;
            regFileRT    = rt_s;
            muxSignals   = MUXB_IMM;
            regFileRD    = rt_s;
            aluOperation = aluop_s;
            regFileRW    = 1'b1;
          end
          C_LOAD: begin
            regFileRS    = rs_s;
            muxSignals   = MUXB_IMM;
            aluOperation = ALU_ADD;
            marEnable    = 1'b1;
            state_next_s = S_M1;
          end
          C_STORE: begin
            regFileRS    = rs_s;
            muxSignals   = MUXB_IMM;
            aluOperation = ALU_ADD;
            marEnable    = 1'b1;
            state_next_s = S_M0;
          end
          C_BEQ, C_BNE: begin
            regFileRS    = rs_s;
            regFileRT    = rt_s;
            aluOperation = ALU_SUB;
            if (taken_s) begin
              nextPC      = branch_target(currentPC, instruction[15:0]);
              muxSignals5 = 1'b1;
              pcEnable    = 1'b1;
            end else begin
              pcEnable    = 1'b0;
            end
          end
          C_J: begin
            nextPC      = jump_target(currentPC, instruction[25:0]);
            muxSignals5 = 1'b1;
            pcEnable    = 1'b1;
          end
          C_JAL: begin
            nextPC       = jump_target(currentPC, instruction[25:0]);
            muxSignals5  = 1'b1;
            pcEnable     = 1'b1;
            muxSignals   = MUXB_PC;
            aluOperation = ALU_ADD;
            regFileRD    = REG_RA;
            regFileRW    = 1'b1;
          end
          C_JR: begin
            regFileRS    = rs_s;
            aluOperation = ALU_ADD;
            pcEnable     = 1'b1;
          end
          C_ERET: begin
            regFileRS    = REG_EPC;
            aluOperation = ALU_ADD;
            pcEnable     = 1'b1;
            ie_next_s    = 1'b1;
          end
          default: begin
            state_next_s = S_CHK;
          end
        endcase
      end

      // Store: move RT through the ALU into MDR before the write cycle
      S_M0: begin
        regFileRT    = rt_s;
        aluOperation = ALU_ADD;
        mdrEnable    = 1'b1;
        state_next_s = S_M2;
      end

      S_M2: begin
        ramMFA      = 1'b1;
        ramRW       = 1'b0;
        ramDataSize = size_s;
        if (ramMFC) begin
          state_next_s = S_CHK;
        end else begin
          state_next_s = S_M2;
        end
      end

      S_M1: begin
        ramMFA      = 1'b1;
        ramRW       = 1'b1;
        ramDataSize = size_s;
        if (ramMFC) begin
          muxSignals2  = 1'b1;
          mdrEnable    = 1'b1;
          state_next_s = S_WB;
        end else begin
          state_next_s = S_M1;
        end
      end

      S_WB: begin
        muxSignals   = MUXB_MDR;
        aluOperation = ALU_ADD;
        regFileRD    = rt_s;
        regFileRW    = 1'b1;
        state_next_s = S_CHK;
      end

      // Interrupt entry: save PC in r26, fetch vector, jump through it
      S_INT0: begin
        muxSignals   = MUXB_PC;
        aluOperation = ALU_ADD;
        regFileRD    = REG_EPC;
        regFileRW    = 1'b1;
        state_next_s = S_INT1;
      end

      S_INT1: begin
        trapMux     = 1'b1;
        ramAddress  = vec_r;
        ramMFA      = 1'b1;
        ramRW       = 1'b1;
        ramDataSize = SIZE_WORD;
        if (ramMFC) begin
          muxSignals2  = 1'b1;
          mdrEnable    = 1'b1;
          state_next_s = S_INT2;
        end else begin
          state_next_s = S_INT1;
        end
      end

      S_INT2: begin
        muxSignals   = MUXB_MDR;
        aluOperation = ALU_ADD;
        pcEnable     = 1'b1;
        state_next_s = S_CHK;
      end

      default: begin
        state_next_s = S_RST;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit. Each instruction is turned into an
// expected per-cycle trace of outputs (plus the inputs to apply that cycle)
// straight from the instruction semantics, then replayed against the DUT.
`timescale 1ns/1ps
module tb_control_unit;

  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010, A_XOR = 4'b0011;
  localparam logic [3:0] A_NOR = 4'b0100, A_SLTU = 4'b0101, A_SUB = 4'b0110, A_SLT = 4'b0111;
  localparam logic [3:0] A_LUI = 4'b1011;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = 32'd0;
  logic [31:0] currentPC = 32'd0;
  logic [3:0]  aluCarryFlags = 4'd0;
  logic        ramMFC = 1'b0;
  logic        hardwareInterrupt = 1'b0;
  logic        maskableInterrupt = 1'b0;
  logic [31:0] nextPC;
  logic        muxSignals5, trapMux, signExtend, clearPC, regFileRW, ramMFA, ramRW;
  logic [3:0]  cmpsignal, aluOperation;
  logic [4:0]  regFileRD, regFileRS, regFileRT;
  logic [1:0]  aluSign, ramDataSize, muxSignals, muxSignals3;
  logic [8:0]  ramAddress;
  logic        pcEnable, irEnable, marEnable, mdrEnable, muxSignals2;

  control_unit dut (
    .Clk(Clk), .reset(reset), .instruction(instruction), .currentPC(currentPC),
    .aluCarryFlags(aluCarryFlags), .ramMFC(ramMFC),
    .hardwareInterrupt(hardwareInterrupt), .maskableInterrupt(maskableInterrupt),
    .nextPC(nextPC), .muxSignals5(muxSignals5), .cmpsignal(cmpsignal), .trapMux(trapMux),
    .signExtend(signExtend), .clearPC(clearPC), .regFileRW(regFileRW),
    .regFileRD(regFileRD), .regFileRS(regFileRS), .regFileRT(regFileRT),
    .aluSign(aluSign), .aluOperation(aluOperation), .ramDataSize(ramDataSize),
    .ramMFA(ramMFA), .ramRW(ramRW), .ramAddress(ramAddress), .pcEnable(pcEnable),
    .irEnable(irEnable), .marEnable(marEnable), .mdrEnable(mdrEnable),
    .muxSignals(muxSignals), .muxSignals2(muxSignals2), .muxSignals3(muxSignals3)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [31:0] nextpc;
    logic        mux5;
    logic [3:0]  cmp;
    logic        trapmux, sext, clearpc, rw;
    logic [4:0]  rd, rs, rt;
    logic [1:0]  alusign;
    logic [3:0]  aluop;
    logic [1:0]  size;
    logic        mfa, ramrw;
    logic [8:0]  ramaddr;
    logic        pce, ire, mare, mdre;
    logic [1:0]  mux1;
    logic        mux2;
    logic [1:0]  mux3;
  } out_t;

  typedef struct packed {
    out_t        o;
    logic        rst, mfc, hw, mi;
    logic [3:0]  flags;
    logic [31:0] pc, ir;
  } step_t;

  step_t q[$];
  int    checks = 0;
  int    failures = 0;
  string cur_tag;
  logic  cur_rst = 1'b0, cur_hw = 1'b0, cur_mi = 1'b0;
  logic [3:0]  cur_flags = 4'd0;
  logic [31:0] cur_pc = 32'd0, cur_ir = 32'd0;
  logic  ie_m = 1'b1;

  function automatic out_t observe();
    out_t r;
    r.nextpc = nextPC;      r.mux5 = muxSignals5;   r.cmp = cmpsignal;
    r.trapmux = trapMux;    r.sext = signExtend;    r.clearpc = clearPC;
    r.rw = regFileRW;       r.rd = regFileRD;       r.rs = regFileRS;
    r.rt = regFileRT;       r.alusign = aluSign;    r.aluop = aluOperation;
    r.size = ramDataSize;   r.mfa = ramMFA;         r.ramrw = ramRW;
    r.ramaddr = ramAddress; r.pce = pcEnable;       r.ire = irEnable;
    r.mare = marEnable;     r.mdre = mdrEnable;     r.mux1 = muxSignals;
    r.mux2 = muxSignals2;   r.mux3 = muxSignals3;
    return r;
  endfunction

  // ALU value of source src routed through with $zero on A
  function automatic out_t pass_of(input logic [1:0] src);
    out_t o = '0;
    o.mux1 = src;
    o.aluop = A_ADD;
    return o;
  endfunction

  task automatic push(input out_t o, input logic mfc);
    step_t s;
    s.o = o; s.rst = cur_rst; s.mfc = mfc; s.hw = cur_hw; s.mi = cur_mi;
    s.flags = cur_flags; s.pc = cur_pc; s.ir = cur_ir;
    q.push_back(s);
  endtask

  // Memory wait: `delay` cycles without MFC, then the completing cycle
  task automatic push_mem(input out_t o, input int delay, input out_t done_o);
    for (int i = 0; i < delay; i++) push(o, 1'b0);
    push(done_o, 1'b1);
  endtask

  function automatic logic [4:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h21: return {1'b1, A_ADD};
      6'h23: return {1'b1, A_SUB};
      6'h24: return {1'b1, A_AND};
      6'h25: return {1'b1, A_OR};
      6'h26: return {1'b1, A_XOR};
      6'h27: return {1'b1, A_NOR};
      6'h2A: return {1'b1, A_SLT};
      6'h2B: return {1'b1, A_SLTU};
      default: return 5'b0;
    endcase
  endfunction

  function automatic logic [4:0] i_alu(input logic [5:0] op);
    case (op)
      6'h09: return {1'b1, A_ADD};
      6'h0A: return {1'b1, A_SLT};
      6'h0C: return {1'b1, A_AND};
      6'h0D: return {1'b1, A_OR};
      6'h0E: return {1'b1, A_XOR};
      6'h0F: return {1'b1, A_LUI};
      default: return 5'b0;
    endcase
  endfunction

  // Execute-and-after cycles for one instruction; pc4 is the advanced PC
  task automatic gen_exec(input logic [31:0] ir, input logic [31:0] pc4, input logic z, input int d_mem);
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, ra, ia;
    logic [15:0] imm;
    logic [1:0] sz;
    logic sx;
    out_t o, d;
    int off;
    op = ir[31:26]; fn = ir[5:0]; rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11]; imm = ir[15:0];
    ra = r_alu(fn); ia = i_alu(op);
    sz = (op == 6'h23 || op == 6'h2B) ? 2'b10 : 2'b00;
    sx = (op == 6'h0C || op == 6'h0D || op == 6'h0E) ? 1'b0 : 1'b1;
    o = '0;
    if (op == 6'h00 && ra[4]) begin
      o.rs = rs; o.rt = rt; o.rd = rd; o.rw = 1'b1; o.aluop = ra[3:0]; o.sext = 1'b1;
      push(o, 1'b0);
    end else if (op == 6'h00 && fn == 6'h08) begin
      o.rs = rs; o.aluop = A_ADD; o.pce = 1'b1; o.sext = 1'b1;
      push(o, 1'b0);
    end else if (ia[4]) begin
      o.rs = rs; o.rt = rt; o.mux1 = 2'b01; o.rd = rt; o.rw = 1'b1; o.aluop = ia[3:0]; o.sext = sx;
      push(o, 1'b0);
    end else if (op == 6'h23 || op == 6'h24 || op == 6'h2B || op == 6'h28) begin
      o.rs = rs; o.mux1 = 2'b01; o.aluop = A_ADD; o.mare = 1'b1; o.sext = 1'b1;
      push(o, 1'b0);
      o = '0; o.mfa = 1'b1; o.size = sz;
      if (op == 6'h23 || op == 6'h24) begin
        o.ramrw = 1'b1;
        d = o; d.mux2 = 1'b1; d.mdre = 1'b1;
        push_mem(o, d_mem, d);
        d = pass_of(2'b10); d.rd = rt; d.rw = 1'b1;
        push(d, 1'b0);
      end else begin
        d = '0; d.rt = rt; d.aluop = A_ADD; d.mdre = 1'b1;
        push(d, 1'b0);
        o.ramrw = 1'b0;
        push_mem(o, d_mem, o);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      o.rs = rs; o.rt = rt; o.aluop = A_SUB; o.sext = 1'b1;
      if (z == (op == 6'h04)) begin
        off = int'($signed(imm)) * 4;
        o.nextpc = pc4 + 32'(off); o.mux5 = 1'b1; o.pce = 1'b1;
      end
      push(o, 1'b0);
    end else if (op == 6'h02 || op == 6'h03) begin
      o.nextpc = (pc4 & 32'hF000_0000) | (32'(ir[25:0]) << 2);
      o.mux5 = 1'b1; o.pce = 1'b1; o.sext = 1'b1;
      if (op == 6'h03) begin
        o.mux1 = 2'b11; o.aluop = A_ADD; o.rd = 5'd31; o.rw = 1'b1;
      end
      push(o, 1'b0);
    end else if (op == 6'h10 && fn == 6'h18) begin
      o.rs = 5'd26; o.aluop = A_ADD; o.pce = 1'b1; o.sext = 1'b1;
      ie_m = 1'b1;
      push(o, 1'b0);
    end else begin
      push(o, 1'b0);
    end
  endtask

  // One instruction boundary: either interrupt entry or fetch + execute
  task automatic gen_instr(input logic [31:0] ir, input logic [31:0] pc, input logic z,
                           input int d_fetch, input int d_mem, input logic hw, input logic mi);
    out_t o, d;
    logic [8:0] vec;
    cur_ir = ir; cur_pc = pc; cur_hw = hw; cur_mi = mi; cur_rst = 1'b0;
    cur_flags = {3'($urandom), z};
    push('0, 1'b0);
    if (hw || (mi && ie_m)) begin
      vec = hw ? 9'h1FC : 9'h1F8;
      ie_m = 1'b0;
      o = pass_of(2'b11); o.rd = 5'd26; o.rw = 1'b1;
      push(o, 1'b0);
      o = '0; o.trapmux = 1'b1; o.ramaddr = vec; o.mfa = 1'b1; o.ramrw = 1'b1; o.size = 2'b10;
      d = o; d.mux2 = 1'b1; d.mdre = 1'b1;
      push_mem(o, d_fetch, d);
      o = pass_of(2'b10); o.pce = 1'b1;
      push(o, 1'b0);
    end else begin
      o = pass_of(2'b11); o.mare = 1'b1;
      push(o, 1'b0);
      o = '0; o.mfa = 1'b1; o.ramrw = 1'b1; o.size = 2'b10;
      d = o; d.ire = 1'b1;
      push_mem(o, d_fetch, d);
      o = '0; o.nextpc = pc + 32'd4; o.mux5 = 1'b1; o.pce = 1'b1;
      push(o, 1'b0);
      cur_pc = pc + 32'd4;
      gen_exec(ir, pc + 32'd4, z, d_mem);
    end
  endtask

  // Replay queued steps: drive on the falling edge, compare 1 ns later
  task automatic run(input string tag);
    step_t s;
    out_t  obs;
    int    n = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge Clk);
      reset = s.rst; ramMFC = s.mfc; hardwareInterrupt = s.hw; maskableInterrupt = s.mi;
      aluCarryFlags = s.flags; currentPC = s.pc; instruction = s.ir;
      #1;
      obs = observe();
      checks++;
      assert (obs === s.o) else begin
        failures++;
        $error("FAIL %s cycle %0d observed=%h expected=%h", tag, n, obs, s.o);
      end
      n++;
    end
  endtask

  initial begin
    step_t s;
    out_t  o;
    logic [25:0] rnd;
    logic [5:0]  op;
    logic [5:0]  r_fn[10] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h08, 6'h00};
    logic [5:0]  i_op[16] = '{6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h24,
                              6'h2B, 6'h28, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F, 6'h10};

    // Reset held for two cycles, then RST state visible for one cycle
    repeat (2) @(posedge Clk);
    o = '0; o.clearpc = 1'b1;
    cur_rst = 1'b1; push(o, 1'b0);
    cur_rst = 1'b0; push(o, 1'b0);
    run("reset");
    ie_m = 1'b1;

    gen_instr({6'h09, 5'd0, 5'd2, 16'd5}, 32'h0000_0000, 1'b0, 1, 1, 1'b0, 1'b0);
    run("addiu");
    gen_instr({6'h23, 5'd1, 5'd3, 16'd8}, 32'h0000_0004, 1'b0, 1, 3, 1'b0, 1'b0);
    run("lw_mfc_delay3");
    gen_instr({6'h2B, 5'd7, 5'd9, 16'hFFFC}, 32'h0000_0008, 1'b0, 0, 0, 1'b0, 1'b0);
    run("sw");
    gen_instr({6'h04, 5'd4, 5'd5, 16'd2}, 32'h0000_0010, 1'b1, 1, 0, 1'b0, 1'b0);
    run("beq_taken");
    gen_instr({6'h04, 5'd4, 5'd5, 16'd2}, 32'h0000_0010, 1'b0, 1, 0, 1'b0, 1'b0);
    run("beq_not_taken");
    gen_instr({6'h05, 5'd4, 5'd5, 16'h0010}, 32'hFFFF_FFF0, 1'b0, 0, 0, 1'b0, 1'b0);
    run("bne_wrap");
    gen_instr({6'h03, 26'h123_4567}, 32'hA000_0100, 1'b0, 0, 0, 1'b0, 1'b0);
    run("jal");

    // Maskable taken, then masked until ERET, hardware always taken
    gen_instr({6'h09, 5'd0, 5'd2, 16'd5}, 32'h0000_0020, 1'b0, 1, 0, 1'b0, 1'b1);
    run("irq_maskable");
    gen_instr({6'h09, 5'd1, 5'd2, 16'd7}, 32'h0000_0100, 1'b0, 1, 0, 1'b0, 1'b1);
    run("irq_masked");
    gen_instr({6'h09, 5'd1, 5'd2, 16'd7}, 32'h0000_0104, 1'b0, 2, 0, 1'b1, 1'b1);
    run("irq_hardware");
    gen_instr(32'h4200_0018, 32'h0000_0200, 1'b0, 0, 0, 1'b0, 1'b0);
    run("eret");
    gen_instr({6'h09, 5'd1, 5'd2, 16'd7}, 32'h0000_0024, 1'b0, 0, 0, 1'b0, 1'b1);
    run("irq_after_eret");

    // Reset during a load's memory wait: MFA must drop on the next edge
    gen_instr({6'h23, 5'd1, 5'd3, 16'd8}, 32'h0000_0040, 1'b0, 0, 2, 1'b0, 1'b0);
    void'(q.pop_back());
    void'(q.pop_back());
    s = q.pop_back(); s.rst = 1'b1; q.push_back(s);
    o = '0; o.clearpc = 1'b1;
    cur_rst = 1'b0; push(o, 1'b0);
    run("reset_mid_load");
    ie_m = 1'b1;
    gen_instr({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 32'h0000_0000, 1'b0, 0, 0, 1'b0, 1'b1);
    run("irq_after_reset");

    // Randomized instruction stream
    for (int it = 0; it < 60; it++) begin
      rnd = 26'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        cur_ir = {6'h00, rnd[25:6], r_fn[$urandom_range(0, 9)]};
      end else begin
        op = i_op[$urandom_range(0, 15)];
        cur_ir = {op, rnd};
        if (op == 6'h10) cur_ir[5:0] = 6'h18;
      end
      gen_instr(cur_ir, {$urandom} & 32'hFFFF_FFFC, 1'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 3), ($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0));
      run("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle control unit of the 32-bit MIPS-subset datapath. It sequences fetch, decode, execute, memory and write-back by driving every select, enable and address in the datapath: register file, ALU, PC/MAR/IR/MDR registers, operand muxes and the 512-byte RAM handshake. It also computes PC+4, branch and jump targets itself, and services a non-maskable and a maskable interrupt at instruction boundaries.

## Interface
- No parameters.
- Clk in 1: rising-edge clock.
- reset in 1: synchronous, active-high.
- instruction in 32: IR contents.
- currentPC in 32: PC register output.
- aluCarryFlags in 4: ALU flags {V,C,N,Z}; bit0 = Z.
- ramMFC in 1: memory function complete.
- hardwareInterrupt in 1: non-maskable request (level).
- maskableInterrupt in 1: maskable request (level).
- nextPC out 32: CU-computed PC value.
- muxSignals5 out 1: PC source; 0 = ALU Y, 1 = nextPC.
- cmpsignal out 4: reserved, always 0.
- trapMux out 1: RAM address source; 0 = MAR[8:0], 1 = ramAddress.
- signExtend out 1: 1 = sign-extend imm16, 0 = zero-extend.
- clearPC out 1: PC synchronous clear.
- regFileRW out 1: 1 = write RD.
- regFileRD, regFileRS, regFileRT out 5 each: register indices.
- aluSign out 2: 01 = signed, 00 = unsigned.
- aluOperation out 4: ALU op code.
- ramDataSize out 2: 00 = byte, 10 = word.
- ramMFA out 1: memory function active.
- ramRW out 1: 1 = read, 0 = write.
- ramAddress out 9: vector address.
- pcEnable, irEnable, marEnable, mdrEnable out 1 each: register load enables.
- muxSignals out 2: ALU-B source; 00 = RT, 01 = imm, 10 = MDR, 11 = PC.
- muxSignals2 out 1: MDR source; 0 = ALU Y, 1 = RAM data.
- muxSignals3 out 2: RD data source; always 00 (ALU Y).

## Operation
- Outputs are Moore-style, decoded from state and IR fields.
- Every output not named below is 0 in that state; regFileRS/RT = 0 means $zero.
- "PASS x": RS=0, mux1 selects x, op ADD, so ALU Y = x.
- ALU ops: AND 0000, OR 0001, ADD 0010, XOR 0011, NOR 0100, SUB 0110, SLT 0111, SLTU 0101, LUI 1011.
- Supported instructions:
  - R-type: ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, JR.
  - I-type: ADDIU, SLTI, ANDI, ORI, XORI, LUI, LW, LBU, SW, SB, BEQ, BNE.
  - Jumps: J, JAL; ERET (op 0x10, funct 0x18).
  - Any other encoding executes as NOP.
- Internal state: IE bit (interrupt enable), 1 after reset; vec register (9 bits).
- States:
  - RST: clearPC=1. → CHK.
  - CHK: hardwareInterrupt → INT0, vec=0x1FC. Else maskableInterrupt&IE → INT0, vec=0x1F8. Else → F0. On interrupt entry IE←0.
  - F0: PASS PC, marEnable. → F1.
  - F1: MFA=1, RW=1, size=10, trapMux=0. When MFC=1: irEnable → F2.
  - F2: nextPC=currentPC+4, mux5=1, pcEnable. → EX.
  - EX, ALU ops: RS=rs, RT=rt, mux1 = 00 (R) or 01 (I), RD = rd (R) or rt (I), regFileRW. → CHK.
  - Sign extension: ANDI/ORI/XORI use signExtend=0; all others use 1.
  - EX, loads/stores: RS=rs, mux1=01, ADD, marEnable. Loads → M1; stores → M0.
  - M0: RT=rt, mux1=00, RS=0, ADD, mux2=0, mdrEnable. → M2.
  - M2: MFA, RW=0, size. Wait for MFC. → CHK.
  - M1: MFA, RW=1, size. On MFC: mux2=1, mdrEnable. → WB.
  - WB: PASS MDR, RD=rt, regFileRW. → CHK.
  - BEQ/BNE: RS=rs, RT=rt, SUB. If (Z==1)==BEQ: nextPC = currentPC + (sext(imm)<<2), mux5=1, pcEnable. → CHK.
  - J/JAL: nextPC = {currentPC[31:28], target, 00}, pcEnable. JAL also does PASS PC, RD=31, regFileRW. → CHK.
  - JR: RS=rs, mux1=00 with RT=0, ADD, mux5=0, pcEnable. → CHK.
  - ERET: same as JR with rs=26; also IE←1.
  - INT0: PASS PC, RD=26, regFileRW. → INT1.
  - INT1: trapMux=1, ramAddress=vec, MFA, RW=1, size=10. On MFC: mux2=1, mdrEnable. → INT2.
  - INT2: PASS MDR, mux5=0, pcEnable. → CHK.

## Timing
- Reset overrides everything: next state RST, IE←1.
- In RST: clearPC=1; all enables, ramMFA and regFileRW are 0.
- Reset asserted mid memory cycle drops ramMFA on the next edge.
- MFA is held high until the cycle in which MFC=1 is sampled.
- The load enable fires in that same cycle; MFA is low in the next state.
- There is no timeout.
- Latency with 1-cycle MFC:
  - ALU instruction, branch, jump: 5 cycles (CHK, F0, F1, F2, EX).
  - Store: 7 cycles.
  - Load: 7 cycles.
  - Interrupt entry: 4 cycles.
- Interrupts are sampled only in CHK; hardware wins when both are asserted.
- Branch target arithmetic is 32-bit wrap-around.

## Structure
- control_unit_pkg holds: state enum, ALU op codes, opcode/funct constants, vector addresses, data-size codes, flag bit indices.
- One sub-module: cu_decoder, a combinational IR to instruction-class/ALU-op/imm-mode decode.

## Test plan
- Reset 2 cycles → clearPC=1 in RST; then F0 with marEnable=1, muxSignals=11, RS=0.
- ADDIU r2,r0,5 with MFC one cycle after MFA:
  - F2: nextPC = currentPC+4, pcEnable.
  - EX: RD=2, mux1=01, signExtend=1, regFileRW=1.
- LW r3,8(r1):
  - MAR load in EX; MDR load (mux2=1) on MFC.
  - WB: mux1=10, RD=3.
  - Delaying MFC 3 cycles holds MFA for 4 cycles.
- BEQ at PC=0x10, imm=2, Z=1 → nextPC=0x1C. With Z=0 → pcEnable=0 in EX.
- maskableInterrupt=1 with IE=1 in CHK:
  - INT0 writes r26.
  - INT1: trapMux=1, ramAddress=0x1F8.
  - Second request is ignored until ERET.
  - hardwareInterrupt taken anyway (ramAddress 0x1FC).
